// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports and one synchronous write port.
// x0 reads as zero and cannot be written.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            write,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] wr_en_d;

  // x0 is a constant; its enable is never raised, so it holds its reset value of zero.
  assign wr_en_d[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_wr_en
      assign wr_en_d[gi] = write && (rd == AW'(gi));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else if (wr_en_d[gi]) begin
          regs_q[gi] <= write_data;
        end
      end
    end
  endgenerate

  // No write-to-read bypass: a pending write becomes visible only after the edge.
  assign read_data1 = (rs1 == '0) ? '0 : regs_q[rs1];
  assign read_data2 = (rs2 == '0) ? '0 : regs_q[rs2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: scoreboard of expected read values,
// checked after combinational settling.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] write_data;
  logic        write;
  logic [31:0] read_data1, read_data2;

  register_file #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_data (write_data),
    .write      (write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } sb_item_t;

  sb_item_t    sb_q[$];
  logic [31:0] model [32];
  int          total_checks = 0;
  int          pass_checks  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs === exp) begin
      pass_checks++;
      $display("check %s: got 0x%08h ok", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive read addresses, push the expectation, let the ports settle, then pop and compare.
  task automatic drive_read(input string tag, input int a, input int b,
                            input logic [31:0] e1, input logic [31:0] e2);
    sb_item_t it;
    rs1 = 5'(a);
    rs2 = 5'(b);
    sb_q.push_back('{tag, e1, e2});
    #1;
    it = sb_q.pop_front();
    check_eq($sformatf("%s_rs1=%0d", it.tag, a), read_data1, it.e1);
    check_eq($sformatf("%s_rs2=%0d", it.tag, b), read_data2, it.e2);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i += 2) drive_read(tag, i, i + 1, model[i], model[i + 1]);
  endtask

  // One clock edge with the given write controls; model updated after the edge.
  task automatic do_cycle(input logic we, input int r, input logic [31:0] d);
    @(negedge clock);
    write      = we;
    rd         = 5'(r);
    write_data = d;
    @(posedge clock);
    #1;
    write = 1'b0;
    if (we && r != 0 && !reset) model[r] = d;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; rd = '0; write_data = '0; rs1 = '0; rs2 = '0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset_held");
    @(negedge clock);
    reset = 1'b0;
    check_all("after_reset");

    // Asynchronous reset mid-cycle clears x5 without an edge.
    do_cycle(1'b1, 5, 32'hDEADBEEF);
    drive_read("x5_written", 5, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    @(negedge clock);
    #1 reset = 1'b1;
    drive_read("async_rst", 5, 0, 32'h0, 32'h0);
    reset = 1'b0;
    clear_model();
    check_all("post_async_rst");

    // Basic writes on consecutive edges.
    do_cycle(1'b1, 1, 32'h00000010);
    do_cycle(1'b1, 31, 32'hFFFFFFFF);
    drive_read("basic", 1, 31, 32'h00000010, 32'hFFFFFFFF);

    // x0 hardwire.
    do_cycle(1'b1, 0, 32'h12345678);
    drive_read("x0_hard", 0, 0, 32'h0, 32'h0);
    check_all("x0_no_side_effect");

    // Collision: old value before the edge, new after; no bypass.
    do_cycle(1'b1, 7, 32'hAAAAAAAA);
    @(negedge clock);
    write = 1'b1; rd = 5'd7; write_data = 32'h55555555;
    drive_read("coll_before", 7, 7, 32'hAAAAAAAA, 32'hAAAAAAAA);
    @(posedge clock);
    #1;
    write = 1'b0;
    model[7] = 32'h55555555;
    drive_read("coll_after", 7, 7, 32'h55555555, 32'h55555555);

    // Write disabled over three edges.
    repeat (3) do_cycle(1'b0, 3, 32'hCAFEF00D);
    drive_read("wr_disable", 3, 3, 32'h0, 32'h0);

    // Reset held across an edge that carries a write to x4.
    @(negedge clock);
    write = 1'b1; rd = 5'd4; write_data = 32'h00000001;
    #4 reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    write = 1'b0;
    reset = 1'b0;
    clear_model();
    drive_read("rst_priority", 4, 4, 32'h0, 32'h0);
    do_cycle(1'b1, 4, 32'h00000002);
    drive_read("first_write_after_rst", 4, 0, 32'h00000002, 32'h0);

    // Random traffic against the reference array.
    for (int n = 0; n < 40; n++) begin
      int          r;
      logic [31:0] d;
      logic        we;
      r  = int'($urandom_range(0, 31));
      d  = $urandom;
      we = ($urandom_range(0, 3) != 0);
      do_cycle(we, r, d);
      begin
        int a, b;
        a = int'($urandom_range(0, 31));
        b = (n % 4 == 0) ? r : int'($urandom_range(0, 31));
        drive_read("rand", a, b, model[a], model[b]);
      end
    end
    check_all("final_sweep");

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit integer register file for the RV32I single-cycle datapath.
- Two combinational read ports (rs1 -> A operand, rs2 -> B operand) feed the ALU.
- One synchronous write port, used for write-back of the ALU result or memory load data to rd.
- Register x0 is hardwired to zero, per the RISC-V ISA.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers (must be a power of two).
- AW, 5, register address width; must equal log2(NREGS).

Ports:
- clock  input  1  single system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears every register.
- rs1  input  AW  read address, port 1.
- rs2  input  AW  read address, port 2.
- rd  input  AW  write address.
- write_data  input  XLEN  data to write into register rd.
- write  input  1  write enable; active high.
- read_data1  output  XLEN  contents of register rs1 (A operand).
- read_data2  output  XLEN  contents of register rs2 (B operand).

Behaviour:
- Storage: NREGS x XLEN flip-flop array; no memory macro.
- Reset:
  - Asserting reset asynchronously clears all registers to 0.
  - Reads follow combinationally, so read_data1 = read_data2 = 0 while reset is high.
  - No write takes effect while reset is high, including a rising edge that coincides with reset.
  - After reset deasserts, the first rising edge with write=1 performs a normal write.
- Write:
  - On a rising clock edge with reset=0, write=1 and rd != 0: reg[rd] <= write_data.
  - write=0 leaves all registers unchanged.
  - rd = 0 is silently ignored: x0 is never written and always reads 0.
- Read:
  - Purely combinational, zero-cycle latency.
  - read_data1 = (rs1 == 0) ? 0 : reg[rs1]; read_data2 likewise for rs2.
  - Outputs update immediately when rs1/rs2 change or when a register changes.
- Read/write collision, when rs1 or rs2 equals rd in the cycle a write is pending:
  - The read port returns the old stored value until the rising edge.
  - The new value appears immediately after that edge.
  - There is no internal write-to-read bypass; forwarding is the datapath's responsibility.
- rs1 == rs2 is legal; both ports return the same value.
- Addresses are exactly AW bits, so no out-of-range access is possible.
- Register values are plain XLEN-bit vectors with no sign or width conversion; sign extension is handled outside this block.
- X-safety: while reset is low and write is low, rd and write_data are don't-care and must not corrupt state.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse reset high mid-cycle (between clock edges) -> read_data1 for rs1=5 drops to 0x00000000 immediately, without waiting for a clock edge; all 32 registers read 0 afterwards.
- Basic write/read:
  - Write x1=0x00000010 and x31=0xFFFFFFFF on consecutive edges.
  - Set rs1=1, rs2=31 -> read_data1=0x00000010, read_data2=0xFFFFFFFF, combinationally.
- x0 hardwire: write=1, rd=0, write_data=0x12345678, clock edge -> rs1=0 reads 0x00000000; no other register is modified.
- Collision timing:
  - x7 holds 0xAAAAAAAA; rs1=rs2=7, rd=7, write=1, write_data=0x55555555.
  - Before the edge, both ports read 0xAAAAAAAA; after the edge, both read 0x55555555.
- Write disable: write=0, rd=3, write_data=0xCAFEF00D over 3 edges -> x3 keeps its prior value (0 after reset).
- Reset priority: reset=1 coincident with a rising edge carrying write=1, rd=4, write_data=0x1 -> x4 reads 0 after reset deasserts.
